// File: rtl/serial_full_subtractor.sv
// rtl/serial_full_subtractor.sv - bit-serial a - b - bin, LSB first, start/busy/done handshake
// Optional signed-overflow output enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             ai, bi, d, br_next, last;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Single full-subtractor cell; on the last cycle ai/bi are the operand MSBs.
  always_comb begin
    ai      = a_sr_q[0];
    bi      = b_sr_q[0];
    d       = ai ^ bi ^ br_q;
    br_next = (~ai & bi) | (~(ai ^ bi) & br_q);
    last    = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_sr_d = a_sr_q;
    b_sr_d = b_sr_q;
    diff_d = diff_q;
    cnt_d  = cnt_q;
    br_d   = br_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ovf_d  = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d = a;
          b_sr_d = b;
          br_d   = bin;
          cnt_d  = '0;
        end
      end
      S_SHIFT: begin
        diff_d = {d, diff_q[WIDTH-1:1]};
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          bout_d = br_next;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          ovf_d  = (ai ^ bi) & (ai ^ d);
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SHIFT) || (state_q == S_DONE);
    done = (state_q == S_DONE);
    diff = diff_q;
    bout = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ovf  = ovf_q;
`endif
  end

endmodule
